// File: rtl/charbuf_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// charbuf_cmd_decoder_pkg
// Shared constants for the character-buffer command decoder.
// The package holds:
//   - the FSM state encoding
//   - the argument command selector
//   - the control/command byte values
//   - the printable character range
//   - a helper that classifies printable bytes
// ---------------------------------------------------------------------------
package charbuf_cmd_decoder_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_TEXT  = 2'd0;
    localparam logic [1:0] ST_ESC   = 2'd1;
    localparam logic [1:0] ST_ARG   = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    // Meaning of the byte that follows an ESC C / ESC P prefix
    localparam logic ARG_COLOR = 1'b0;
    localparam logic ARG_POS   = 1'b1;

    // Control and command bytes
    localparam logic [7:0] BYTE_ESC       = 8'h1B;
    localparam logic [7:0] BYTE_CR        = 8'h0D;
    localparam logic [7:0] BYTE_CMD_COLOR = 8'h43;  // 'C'
    localparam logic [7:0] BYTE_CMD_POS   = 8'h50;  // 'P'
    localparam logic [7:0] BYTE_CMD_CLEAR = 8'h58;  // 'X'
    localparam logic [7:0] BYTE_SPACE     = 8'h20;

    // Printable range, inclusive on both ends
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/charbuf_cmd_decoder.sv
// ---------------------------------------------------------------------------
// charbuf_cmd_decoder
// Turns a UART byte stream into character-buffer writes.
//
// Byte handling:
//   - Printable bytes are written at the cursor, which wraps at last_index.
//   - CR returns the cursor to address 0 without writing.
//   - ESC C <n> sets the current color to n[3:0].
//   - ESC P <n> sets the cursor to min(n, last_index).
//   - ESC X fills the whole buffer with spaces. The clear takes MAX_CHARS
//     cycles, and no bytes are accepted while it runs.
//
// Ports:
//   clk, reset      single clock; synchronous active-high reset
//   in_data/valid   received byte and its qualifier
//   in_ready        byte accepted when in_valid && in_ready at a rising edge
//   last_index      highest active buffer address
//   wr_en           one-cycle write strobe
//   wr_addr         write address; holds its value when wr_en is 0
//   wr_char         write data; holds its value when wr_en is 0
//   wr_color        write color; holds its value when wr_en is 0
//   cursor          next text write address
//   busy            high while the buffer clear runs
//
// MAX_CHARS must be a power of two in the range 2..128.
// ---------------------------------------------------------------------------
module charbuf_cmd_decoder
    import charbuf_cmd_decoder_pkg::*;
#(
    parameter int         MAX_CHARS     = 8,
    parameter logic [3:0] DEFAULT_COLOR = 4'd1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(MAX_CHARS)-1:0] last_index,
    output logic                         wr_en,
    output logic [$clog2(MAX_CHARS)-1:0] wr_addr,
    output logic [7:0]                   wr_char,
    output logic [3:0]                   wr_color,
    output logic [$clog2(MAX_CHARS)-1:0] cursor,
    output logic                         busy
);

    localparam int AW = $clog2(MAX_CHARS);
    localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(MAX_CHARS - 1);

    logic [1:0]    state_r,    state_s;
    logic [AW-1:0] cursor_r,   cursor_s;
    logic [3:0]    color_r,    color_s;
    logic          arg_cmd_r,  arg_cmd_s;
    logic          wr_en_r,    wr_en_s;
    logic [AW-1:0] wr_addr_r,  wr_addr_s;
    logic [7:0]    wr_char_r,  wr_char_s;
    logic [3:0]    wr_color_r, wr_color_s;
    logic [AW-1:0] eff_s;
    logic          accept_s;

    assign in_ready = (state_r != ST_CLEAR);
    assign busy     = (state_r == ST_CLEAR);
    assign accept_s = in_valid && in_ready;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_char  = wr_char_r;
    assign wr_color = wr_color_r;
    assign cursor   = cursor_r;

    // Next-state, cursor, color and write-request logic.
    always_comb begin
        state_s    = state_r;
        cursor_s   = cursor_r;
        color_s    = color_r;
        arg_cmd_s  = arg_cmd_r;
        wr_en_s    = 1'b0;
        wr_addr_s  = wr_addr_r;
        wr_char_s  = wr_char_r;
        wr_color_s = wr_color_r;
        // A cursor left beyond a shrunken last_index restarts at 0.
        if (cursor_r > last_index) begin
            eff_s = ADDR_ZERO;
        end else begin
            eff_s = cursor_r;
        end

        case (state_r)
            ST_TEXT: begin
                if (accept_s) begin
                    if (is_printable(in_data)) begin
                        wr_en_s    = 1'b1;
                        wr_addr_s  = eff_s;
                        wr_char_s  = in_data;
                        wr_color_s = color_r;
                        if (eff_s == last_index) begin
                            cursor_s = ADDR_ZERO;
                        end else begin
                            cursor_s = eff_s + ADDR_ONE;
                        end
                    end else if (in_data == BYTE_CR) begin
                        cursor_s = ADDR_ZERO;
                    end else if (in_data == BYTE_ESC) begin
                        state_s = ST_ESC;
                    end else begin
                        state_s = ST_TEXT;
                    end
                end else begin
                    state_s = ST_TEXT;
                end
            end
            ST_ESC: begin
                if (accept_s) begin
                    if (in_data == BYTE_CMD_COLOR) begin
                        state_s   = ST_ARG;
                        arg_cmd_s = ARG_COLOR;
                    end else if (in_data == BYTE_CMD_POS) begin
                        state_s   = ST_ARG;
                        arg_cmd_s = ARG_POS;
                    end else if (in_data == BYTE_CMD_CLEAR) begin
                        // The cursor register doubles as the clear address counter.
                        state_s  = ST_CLEAR;
                        cursor_s = ADDR_ZERO;
                    end else begin
                        state_s = ST_TEXT;
                    end
                end else begin
                    state_s = ST_ESC;
                end
            end
            ST_ARG: begin
                if (accept_s) begin
                    state_s = ST_TEXT;
                    if (arg_cmd_r == ARG_COLOR) begin
                        color_s = in_data[3:0];
                    end else if (in_data > 8'(last_index)) begin
                        // Compare the full byte, so that large positions clamp
                        // instead of aliasing.
                        cursor_s = last_index;
                    end else begin
                        cursor_s = in_data[AW-1:0];
                    end
                end else begin
                    state_s = ST_ARG;
                end
            end
            ST_CLEAR: begin
                wr_en_s    = 1'b1;
                wr_addr_s  = cursor_r;
                wr_char_s  = BYTE_SPACE;
                wr_color_s = color_r;
                // The counter wraps to 0 after the last address, which is
                // also the cursor value the clear must leave behind.
                cursor_s   = cursor_r + ADDR_ONE;
                if (cursor_r == ADDR_LAST) begin
                    state_s = ST_TEXT;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            default: begin
                state_s = ST_TEXT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_TEXT;
            cursor_r   <= ADDR_ZERO;
            color_r    <= DEFAULT_COLOR;
            arg_cmd_r  <= ARG_COLOR;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= ADDR_ZERO;
            wr_char_r  <= 8'h00;
            wr_color_r <= 4'h0;
        end else begin
            state_r    <= state_s;
            cursor_r   <= cursor_s;
            color_r    <= color_s;
            arg_cmd_r  <= arg_cmd_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_char_r  <= wr_char_s;
            wr_color_r <= wr_color_s;
        end
    end

endmodule

// File: tb/tb_charbuf_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_charbuf_cmd_decoder
// Bench for charbuf_cmd_decoder.
//
// A byte-sequence reference model predicts the following on every cycle:
//   - the outputs in_ready, busy and wr_en
//   - the write fields wr_addr, wr_char and wr_color
//   - the cursor
//
// The model interprets pending escape prefixes as a queue and tracks a
// clear as a remaining-writes count. Directed sequences with literal
// expectations pin the model. Randomized traffic then runs against it.
// ---------------------------------------------------------------------------
module tb_charbuf_cmd_decoder;

    localparam int MAXC = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] last_index = 3'd7;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_char;
    logic [3:0]    wr_color;
    logic [AW-1:0] cursor;
    logic          busy;

    charbuf_cmd_decoder #(.MAX_CHARS(MAXC), .DEFAULT_COLOR(4'd1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .last_index(last_index), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_char(wr_char), .wr_color(wr_color),
        .cursor(cursor), .busy(busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    bit         armed = 1'b0;
    bit         m_acc = 1'b0;
    bit         m_wr_en = 1'b0;
    int         m_addr = 0;
    int         m_char = 0;
    int         m_col = 0;
    int         m_cursor = 0;
    logic [3:0] m_color = 4'd1;
    int         clear_left = 0;
    logic [7:0] pend[$];

    typedef struct { int a; int c; int col; } wr_t;
    wr_t obs_q[$];
    int  busy_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one step per rising edge, from the inputs seen at that edge.
    always @(posedge clk) begin
        int eff;
        int li;
        logic [7:0] b;
        m_acc   = 1'b0;
        m_wr_en = 1'b0;
        li = int'(last_index);
        b  = in_data;
        if (reset) begin
            armed = 1'b1;
            m_cursor = 0; m_color = 4'd1; clear_left = 0; pend.delete();
            m_addr = 0; m_char = 0; m_col = 0;
        end else if (clear_left > 0) begin
            m_wr_en = 1'b1; m_addr = MAXC - clear_left; m_char = 8'h20; m_col = int'(m_color);
            clear_left--;
            m_cursor = (MAXC - clear_left) % MAXC;
        end else if (in_valid) begin
            m_acc = 1'b1;
            if (pend.size() == 0) begin
                if (b >= 8'h20 && b <= 8'h7E) begin
                    eff = (m_cursor > li) ? 0 : m_cursor;
                    m_wr_en = 1'b1; m_addr = eff; m_char = int'(b); m_col = int'(m_color);
                    m_cursor = (eff == li) ? 0 : eff + 1;
                end else if (b == 8'h0D) begin
                    m_cursor = 0;
                end else if (b == 8'h1B) begin
                    pend.push_back(b);
                end
            end else if (pend.size() == 1) begin
                if (b == 8'h43 || b == 8'h50) begin
                    pend.push_back(b);
                end else begin
                    pend.delete();
                    if (b == 8'h58) begin
                        clear_left = MAXC;
                        m_cursor = 0;
                    end
                end
            end else begin
                if (pend[1] == 8'h43) m_color = b[3:0];
                else m_cursor = (int'(b) > li) ? li : int'(b);
                pend.delete();
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(clear_left == 0));
            chk("busy",     32'(busy),     32'(clear_left > 0));
            chk("wr_en",    32'(wr_en),    32'(m_wr_en));
            chk("wr_addr",  32'(wr_addr),  m_addr);
            chk("wr_char",  32'(wr_char),  m_char);
            chk("wr_color", 32'(wr_color), m_col);
            chk("cursor",   32'(cursor),   m_cursor);
            if (wr_en) obs_q.push_back('{int'(wr_addr), int'(wr_char), int'(wr_color)});
            if (busy) busy_cycles++;
        end
    end

    task automatic send(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_acc && waited < 64);
        if (!m_acc) begin
            compared++; mismatched++;
            $display("FAIL send_timeout byte %0h not accepted within %0d cycles", b, waited);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        obs_q.delete();
        busy_cycles = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_wr(input int idx, input int a, input int c, input int col);
        if (idx < obs_q.size()) begin
            chk($sformatf("wr%0d_addr", idx), obs_q[idx].a, a);
            chk($sformatf("wr%0d_char", idx), obs_q[idx].c, c);
            chk($sformatf("wr%0d_color", idx), obs_q[idx].col, col);
        end else begin
            compared++; mismatched++;
            $display("FAIL wr%0d_missing got %0d writes", idx, obs_q.size());
        end
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 11))
            0:       return 8'h1B;
            1:       return 8'h0D;
            2:       return 8'h43;
            3:       return 8'h50;
            4:       return ($urandom_range(0, 3) == 0) ? 8'h58 : 8'h41;
            5:       return 8'($urandom_range(0, 255));
            6:       return 8'($urandom_range(0, 31));
            default: return 8'($urandom_range(32, 126));
        endcase
    endfunction

    initial begin
        logic [7:0] txt[5];
        txt = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        idle(2);
        reset = 1'b0;

        // Reset state, checked literally.
        idle(1);
        chk("rst_cursor", 32'(cursor), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_ready", 32'(in_ready), 1);

        // "ABCDE" with last_index 3 wraps from address 3 back to 0.
        last_index = 3'd3;
        do_reset();
        foreach (txt[i]) send(txt[i]);
        idle(2);
        chk("abcde_count", obs_q.size(), 5);
        chk_wr(0, 0, 8'h41, 1); chk_wr(1, 1, 8'h42, 1); chk_wr(2, 2, 8'h43, 1);
        chk_wr(3, 3, 8'h44, 1); chk_wr(4, 0, 8'h45, 1);
        chk("abcde_cursor", 32'(cursor), 1);

        // The color escape writes nothing itself and changes the color of the next write.
        last_index = 3'd7;
        do_reset();
        send(8'h1B); send(8'h43); send(8'h05); send(8'h5A);
        idle(2);
        chk("color_count", obs_q.size(), 1);
        chk_wr(0, 0, 8'h5A, 5);

        // A position argument beyond last_index clamps to last_index.
        last_index = 3'd3;
        do_reset();
        send(8'h1B); send(8'h50); send(8'h09); send(8'h51);
        idle(2);
        chk("pos_count", obs_q.size(), 1);
        chk_wr(0, 3, 8'h51, 1);
        chk("pos_cursor", 32'(cursor), 0);

        // Clear with in_valid held high; 'A' waits until the clear ends.
        last_index = 3'd7;
        do_reset();
        send(8'h1B); send(8'h58); send(8'h41);
        idle(2);
        chk("clear_busy_cycles", busy_cycles, 8);
        chk("clear_count", obs_q.size(), 9);
        for (int i = 0; i < 8; i++) chk_wr(i, i, 8'h20, 1);
        chk_wr(8, 0, 8'h41, 1);
        chk("clear_cursor", 32'(cursor), 1);

        // Reset during the 3rd clear cycle aborts the clear.
        do_reset();
        send(8'h1B); send(8'h43); send(8'h06);
        obs_q.delete();
        send(8'h1B); send(8'h58);
        idle(2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_wr_en", 32'(wr_en), 0);
        chk("abort_busy", 32'(busy), 0);
        send(8'h41);
        idle(2);
        chk("abort_count", obs_q.size(), 3);
        chk_wr(0, 0, 8'h20, 6); chk_wr(1, 1, 8'h20, 6); chk_wr(2, 0, 8'h41, 1);

        // Non-printable bytes and an unknown escape command are discarded.
        do_reset();
        send(8'h07); send(8'h80); send(8'h1B); send(8'h51); send(8'h61);
        idle(2);
        chk("discard_count", obs_q.size(), 1);
        chk_wr(0, 0, 8'h61, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = pick_byte();
            reset    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) last_index = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
